mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
Sequential unsigned shift-and-add multiplier controller that time-shares a single WIDTH-bit ripple adder over WIDTH iterations.
Sits beside the ALU datapath as the multi-cycle MUL engine, trading area for latency.
Start/busy/done handshake toward the ALU control.
Full 2*WIDTH-bit product returned.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 4..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when state is IDLE or DONE
a  input  WIDTH  multiplicand, captured on accepted start
b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse when product becomes valid
product  output  2*WIDTH  result register, held until next completion

Behaviour:
- Interface: one clock (clk); reset asynchronous and active-low (rst_n).
- Reset: rst_n low forces the following immediately, independent of clk:
  - state=IDLE
  - busy=0, done=0, product=0
  - internal mcand, acc_hi, acc_lo (multiplier/low half), carry, count cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads mcand<=a, acc_hi<=0, acc_lo<=b, count<=0.
  - Transitions to RUN.
  - start=0 stays IDLE.
- RUN, one iteration per clock:
  - Adder computes {c, s} = acc_hi + (acc_lo[0] ? mcand : 0) with c_in=0. The adder is always exercised; the operand is zero-masked, not bypassed.
  - Register update: {acc_hi, acc_lo} <= {c, s, acc_lo[WIDTH-1:1]}, a right shift of 2*WIDTH+1 bits keeping the low 2*WIDTH.
  - count increments. On the iteration where count==WIDTH-1, next state is DONE.
  - start is ignored in RUN; a and b are not sampled.
- DONE:
  - Entered for exactly one cycle. product <= {acc_hi, acc_lo} at the edge entering DONE; done=1, busy=0 during DONE.
  - start=1 in DONE: accepted exactly as in IDLE (back-to-back, no bubble); next state RUN.
  - start=0 in DONE: next state IDLE.
- Latency:
  - Start sampled at edge E0; busy=1 from E0 through E0+WIDTH.
  - done=1 and product valid in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- product holds its value through IDLE and the next RUN; it changes only on entry to DONE or reset.
- Arithmetic: unsigned only. No overflow possible (2*WIDTH result). All-ones × all-ones = 2^(2*WIDTH) - 2^(WIDTH+1) + 1 exactly.
- Reset asserted mid-RUN aborts the operation:
  - No done pulse; product=0.
  - After rst_n rises, first accepted start behaves as from power-up.
- X/unknown on a/b outside an accepted start must not propagate into state.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined:
  - In RUN, if acc_lo's remaining unprocessed multiplier bits (top WIDTH-count bits of the shifted multiplier) are all zero, the block performs the remaining (WIDTH-count) right shifts in one cycle and goes to DONE next.
  - Latency becomes 1 + (index of highest set bit of b, +1), minimum 2 cycles (b=0 → done 2 cycles after start).
  - Result is identical to full-latency mode.
- Undefined: fixed WIDTH+1 latency regardless of operands; no early-exit logic synthesized.

Test Plan:
- WIDTH=8, a=13, b=11, start one cycle → busy 8 cycles, done pulse 9 cycles after start edge, product=143; product holds 143 for 20 idle cycles.
- WIDTH=8, a=255, b=255 → product=65025 (0xFE01); WIDTH=32 a=b=0xFFFFFFFF → product=0xFFFFFFFE00000001.
- WIDTH=8, a=0 b=200 then a=200 b=0 back-to-back, start held high through DONE → second op starts with no idle cycle, both products=0, two done pulses 9 cycles apart.
- WIDTH=8, a=7 b=9 accepted, start re-pulsed with a=3 b=3 at RUN cycle 4 → ignored, product=63, single done pulse.
- WIDTH=8, a=50 b=60 accepted, rst_n low at RUN cycle 3 asynchronously (mid-cycle) → busy/done/product drop to 0 immediately, no done; after release a=6 b=7 → product=42.
- MUL_EARLY_TERM_EN, WIDTH=8: a=5 b=1 → done 2 cycles after start, product=5; a=5 b=128 → done 9 cycles after start, product=640; without macro both take 9 cycles.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add unsigned multiplier: one WIDTH-bit adder reused over WIDTH RUN cycles, product valid WIDTH+1 cycles after start.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero (same result, shorter latency).
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q,  acc_lo_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   step;
    logic                 last;

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0]     rem_bits;
    logic [CW-1:0]        rem_shift;
`endif

    always_comb begin
        // Adder always runs; a zero multiplier bit masks the operand rather than bypassing the adder.
        addend = mcand_q & {WIDTH{acc_lo_q[0]}};
        sum    = {1'b0, acc_hi_q} + {1'b0, addend};
        step   = {sum, acc_lo_q[WIDTH-1:1]};
        last   = (count_q == CW'(WIDTH - 1));
`ifdef MUL_EARLY_TERM_EN
        // Multiplier bits not yet consumed sit in acc_lo[WIDTH-1-count:1] after this cycle's bit.
        rem_bits  = acc_lo_q & ({WIDTH{1'b1}} >> count_q) & ~WIDTH'(1);
        rem_shift = CW'(WIDTH - 1) - count_q;
        if (rem_bits == '0) begin
            step = step >> rem_shift;
            last = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    count_d  = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                {acc_hi_d, acc_lo_d} = step;
                count_d = count_q + CW'(1);
                if (last) begin
                    product_d = step;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl at WIDTH=8 (main) and WIDTH=32 (all-ones corner).
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] product32;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busycnt = 0;

    typedef struct {
        logic [15:0] prod;
        int          cyc0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    mul_seq_ctrl #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .product(product32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_lat(input int w, input logic [63:0] bv);
        int h;
        h = -1;
`ifdef MUL_EARLY_TERM_EN
        for (int i = 0; i < w; i++) if (bv[i]) h = i;
        return (h < 0) ? 2 : h + 2;
`else
        h = w;
        return h + 1;
`endif
    endfunction

    // Monitor: pops one expectation per done pulse, checks product, latency and busy span.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busycnt = 0;
        end else if (done8) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("product", product8, e.prod);
                check("done_latency", cyc - e.cyc0, e.lat - 1);
                check("busy_cycles", busycnt, e.lat - 1);
            end
            busycnt = 0;
        end else if (busy8) begin
            busycnt++;
        end
    end

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy8) check("wait_not_busy_timeout", 1, 0);
    endtask

    task automatic push_exp(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        e.prod = 16'(av) * 16'(bv);
        e.cyc0 = cyc;
        e.lat  = exp_lat(8, 64'(bv));
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit expect_done);
        wait_not_busy();
        @(negedge clk);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(posedge clk);
        #1;
        if (expect_done) push_exp(av, bv);
        start8 = 1'b0;
        a8 = 'x;
        b8 = 'x;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        #2;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_product", product8, 0);
        check("rst_product32", product32, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic op plus hold through idle cycles.
        run_op(8'd13, 8'd11, 1'b1);
        drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_143", product8, 16'd143);
        end

        run_op(8'd255, 8'd255, 1'b1);
        drain();
        check("allones8", product8, 16'hFE01);

        // Back-to-back: start held through DONE, second op accepted with no bubble.
        wait_not_busy();
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd0; b8 = 8'd200;
        @(posedge clk); #1;
        push_exp(8'd0, 8'd200);
        a8 = 8'd200; b8 = 8'd0;
        n = 0;
        while (!done8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_done_seen", done8, 1);
        @(posedge clk); #1;
        push_exp(8'd200, 8'd0);
        check("b2b_no_bubble_busy", busy8, 1);
        start8 = 1'b0; a8 = 'x; b8 = 'x;
        drain();

        // Start re-pulsed during RUN must be ignored.
        run_op(8'd7, 8'd9, 1'b1);
        if (busy8) begin
            repeat (3) @(posedge clk);
            #1;
            start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
            @(posedge clk); #1;
            start8 = 1'b0; a8 = 'x; b8 = 'x;
        end
        drain();
        check("ignore_restart", product8, 16'd63);

        // Asynchronous reset mid-RUN aborts, then a fresh op works.
        run_op(8'd50, 8'd60, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_product", product8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_done_product", product8, 0);
        run_op(8'd6, 8'd7, 1'b1);
        drain();

        // Early-termination latency corners (full latency when the feature is off).
        run_op(8'd5, 8'd1, 1'b1);
        drain();
        run_op(8'd5, 8'd128, 1'b1);
        drain();

        // WIDTH=32 all-ones corner.
        @(negedge clk);
        start32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = 'x; b32 = 'x;
        check("w32_busy", busy32, 1);
        n = 0;
        while (!done32 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("w32_done_latency", 64'(n), 64'(exp_lat(32, 64'hFFFF_FFFF) - 1));
        check("w32_product", product32, 64'hFFFF_FFFE_0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
